// File: rtl/intf_array_rr_pkg.sv
// -----------------------------------------------------------------------------
// intf_array_rr_pkg
// Shared types for the interface-array round-robin mux.
//   ch_idx_t    : channel index, wide enough for the largest supported array
//                 (16 channels); the top truncates it to $clog2(NUM_CH) bits
//                 for its out_ch port.
//   STATS_W     : width of the optional per-channel grant counters.
//   rr_state_t  : IDLE (nothing held) / PRESENT (out_valid asserted).
// -----------------------------------------------------------------------------
package intf_array_rr_pkg;

   localparam int MAX_CH  = 16;
   localparam int STATS_W = 16;

   typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } rr_state_t;

endpackage

// File: rtl/intf_array_rr_chan_intf.sv
// -----------------------------------------------------------------------------
// chan_intf
// One input channel of the round-robin mux: valid/ready handshake plus payload.
//   valid : producer has a beat
//   ready : slot can take the beat this cycle
//   data  : payload, WIDTH bits
// The slot modport is the view a storage slot has of its channel.
// -----------------------------------------------------------------------------
interface chan_intf #(
   parameter int WIDTH = 8
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport slot (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/intf_array_rr_slot.sv
// -----------------------------------------------------------------------------
// intf_array_rr_slot
// Single-entry holding register for one channel of the round-robin mux.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ch         : channel handshake (valid/data in, ready out)
//   drain      : the top is taking this slot's entry on the output this cycle
//   full       : entry is occupied
//   data       : stored payload
// -----------------------------------------------------------------------------
module intf_array_rr_slot
   import intf_array_rr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   chan_intf.slot           ch,
   input  logic             drain,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic load;

   // A full slot can still accept when it is being drained in the same cycle,
   // so one channel can stream a beat every cycle.
   assign ch.ready = !full || drain;
   assign load     = ch.valid && ch.ready;

   // Load wins over drain so a simultaneous drain and refill keeps the slot full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= ch.data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/intf_array_rr_mux.sv
// -----------------------------------------------------------------------------
// intf_array_rr_mux
// Merges NUM_CH valid/ready channels into one output stream with round-robin
// arbitration. Each channel has a one-entry slot; the arbiter picks the first
// full slot at or after ptr, and holds that choice while the output stalls.
// Parameters: NUM_CH (2..16), WIDTH (1..64).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_data    : per-channel request and payload
//   in_ready            : per-channel accept
//   out_valid/out_data  : merged output, out_ch = source channel
//   out_ready           : downstream accept
//   grant_cnt           : per-channel saturating grant counters, present only
//                         when INTF_ARRAY_RR_MUX_STATS_EN is defined
// -----------------------------------------------------------------------------
module intf_array_rr_mux
   import intf_array_rr_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            in_valid,
   input  logic [NUM_CH-1:0][WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(NUM_CH)-1:0]    out_ch,
   input  logic                         out_ready
`ifdef INTF_ARRAY_RR_MUX_STATS_EN
   ,
   output logic [NUM_CH-1:0][STATS_W-1:0] grant_cnt
`endif
);

   rr_state_t         state_q, state_d;
   ch_idx_t           ptr_q, held_ch_q, arb_ch, sel_ch, hi_ch, lo_ch;
   logic              lock_q, out_xfer, found_hi;
   logic [NUM_CH-1:0] full_vec, drain_vec, in_xfer_vec, remain_vec;
   logic [WIDTH-1:0]  slot_data [NUM_CH];
   logic [WIDTH-1:0]  sel_data;

   chan_intf #(.WIDTH(WIDTH)) ch_if [NUM_CH] ();

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_if[i].valid = in_valid[i];
      assign ch_if[i].data  = in_data[i];
      assign in_ready[i]    = ch_if[i].ready;

      intf_array_rr_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .ch    (ch_if[i]),
         .drain (drain_vec[i]),
         .full  (full_vec[i]),
         .data  (slot_data[i])
      );
   end

   // Round-robin search: scanning downward leaves the lowest full index in
   // lo_ch and the lowest full index at or above ptr in hi_ch; the latter wins,
   // otherwise the search wraps to the lowest full channel.
   always_comb begin
      found_hi = 1'b0;
      hi_ch    = '0;
      lo_ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (full_vec[i]) begin
            lo_ch = ch_idx_t'(i);
            if (ch_idx_t'(i) >= ptr_q) begin
               hi_ch    = ch_idx_t'(i);
               found_hi = 1'b1;
            end
         end
      end
      arb_ch = found_hi ? hi_ch : lo_ch;
   end

   // While a presented beat is stalled, the held channel overrides the arbiter
   // so out_ch/out_data cannot change under the downstream's feet.
   assign sel_ch    = lock_q ? held_ch_q : arb_ch;
   assign out_valid = (state_q == PRESENT);
   assign out_xfer  = out_valid && out_ready;

   // Output mux and per-slot drain strobe, decoded from the selected channel.
   always_comb begin
      sel_data  = '0;
      drain_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx_t'(i) == sel_ch) begin
            sel_data     = slot_data[i];
            drain_vec[i] = out_xfer;
         end
      end
   end

   assign out_data    = out_valid ? sel_data : '0;
   assign out_ch      = out_valid ? sel_ch[$clog2(NUM_CH)-1:0] : '0;
   assign in_xfer_vec = in_valid & in_ready;
   assign remain_vec  = (full_vec & ~drain_vec) | in_xfer_vec;

   // IDLE/PRESENT tracks whether any slot will be occupied after this edge,
   // which keeps out_valid equal to the OR of the slot full flags.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|in_xfer_vec) state_d = PRESENT;
         PRESENT: if (out_xfer && !(|remain_vec)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin pointer and stall lock. The pointer moves one past the
   // granted channel only on an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         lock_q    <= 1'b0;
         held_ch_q <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= out_valid && !out_ready;
         if (out_valid && !out_ready) begin
            held_ch_q <= sel_ch;
         end
         if (out_xfer) begin
            ptr_q <= (sel_ch == ch_idx_t'(NUM_CH - 1)) ? '0 : sel_ch + ch_idx_t'(1);
         end
      end
   end

`ifdef INTF_ARRAY_RR_MUX_STATS_EN
   // Per-channel grant counters, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (drain_vec[i] && (grant_cnt[i] != '1)) begin
               grant_cnt[i] <= grant_cnt[i] + STATS_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_intf_array_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_intf_array_rr_mux
// Directed bench for intf_array_rr_mux (NUM_CH=4, WIDTH=8): single beat,
// fairness, stall lock, drain+refill, mid-operation reset, and the grant
// counters when INTF_ARRAY_RR_MUX_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_intf_array_rr_mux;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_CH-1:0]            in_valid;
   logic [NUM_CH-1:0][WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]            in_ready;
   logic                         out_valid;
   logic [WIDTH-1:0]             out_data;
   logic [1:0]                   out_ch;
   logic                         out_ready;
`ifdef INTF_ARRAY_RR_MUX_STATS_EN
   logic [NUM_CH-1:0][15:0]      grant_cnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   intf_array_rr_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
`ifdef INTF_ARRAY_RR_MUX_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   // Drive all DUT inputs at once; data is {ch3, ch2, ch1, ch0}.
   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                input logic ready);
      in_valid  = valid;
      in_data   = data;
      out_ready = ready;
   endtask

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      $display("[TB] start");
      rst_n = 1'b0;
      applyStimulus(4'b0000, 32'h0, 1'b0);
      #2;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 4'b1111);
      checkOutput("rst_out_ch", out_ch, 0);
      checkOutput("rst_out_data", out_data, 0);
      tick();
      rst_n = 1'b1;

      // Single channel: ch2 sends A5, presented one cycle later, then gone.
      applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
      #1;
      checkOutput("single_pre_valid", out_valid, 0);
      tick();
      applyStimulus(4'b0000, 32'h0, 1'b1);
      #1;
      checkOutput("single_valid", out_valid, 1);
      checkOutput("single_ch", out_ch, 2);
      checkOutput("single_data", out_data, 8'hA5);
      tick();
      checkOutput("single_after_valid", out_valid, 0);
      checkOutput("single_after_ch", out_ch, 0);
      checkOutput("single_after_data", out_data, 0);

      // Fairness: all channels valid every cycle, strict rotation from ptr=0.
      pulseReset();
      applyStimulus(4'b1111, 32'h5352_5150, 1'b1);
      for (int k = 0; k < 8; k++) begin
         tick();
         checkOutput($sformatf("fair_valid%0d", k), out_valid, 1);
         checkOutput($sformatf("fair_ch%0d", k), out_ch, k % 4);
         checkOutput($sformatf("fair_data%0d", k), out_data, 8'h50 + (k % 4));
      end

      // Stall lock: ch1 stalled, ch0 fills behind it; ch1 stays put.
      pulseReset();
      applyStimulus(4'b0110, 32'h0022_1100, 1'b0);
      tick();
      applyStimulus(4'b0001, 32'h0022_1199, 1'b0);
      #1;
      checkOutput("lock_first_ch", out_ch, 1);
      checkOutput("lock_first_data", out_data, 8'h11);
      checkOutput("lock_first_ready", in_ready, 4'b1001);
      tick();
      applyStimulus(4'b0000, 32'h0, 1'b0);
      #1;
      checkOutput("lock_hold_ch", out_ch, 1);
      checkOutput("lock_hold_data", out_data, 8'h11);
      checkOutput("lock_hold_ready", in_ready, 4'b1000);
      tick();
      checkOutput("lock_hold2_ch", out_ch, 1);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      #1;
      checkOutput("lock_release_ch", out_ch, 1);
      tick();
      checkOutput("lock_next_ch", out_ch, 2);
      checkOutput("lock_next_data", out_data, 8'h22);
      tick();
      checkOutput("lock_wrap_ch", out_ch, 0);
      checkOutput("lock_wrap_data", out_data, 8'h99);
      tick();
      checkOutput("lock_empty_valid", out_valid, 0);

      // Drain plus refill on ch3 in the same cycle.
      applyStimulus(4'b1000, 32'h3300_0000, 1'b0);
      tick();
      checkOutput("refill_full_ready", in_ready[3], 0);
      checkOutput("refill_first_ch", out_ch, 3);
      checkOutput("refill_first_data", out_data, 8'h33);
      applyStimulus(4'b1000, 32'h3C00_0000, 1'b1);
      #1;
      checkOutput("refill_drain_ready", in_ready[3], 1);
      tick();
      applyStimulus(4'b0000, 32'h0, 1'b1);
      #1;
      checkOutput("refill_second_valid", out_valid, 1);
      checkOutput("refill_second_ch", out_ch, 3);
      checkOutput("refill_second_data", out_data, 8'h3C);
      tick();
      checkOutput("refill_done_valid", out_valid, 0);

      // Mid-operation reset with three channels full and ptr=1.
      applyStimulus(4'b0111, 32'h0062_6160, 1'b0);
      tick();
      applyStimulus(4'b0001, 32'h0062_6170, 1'b1);
      #1;
      checkOutput("mrst_pre_ch", out_ch, 0);
      checkOutput("mrst_pre_data", out_data, 8'h60);
      tick();
      applyStimulus(4'b0000, 32'h0, 1'b0);
      #1;
      checkOutput("mrst_ptr1_ch", out_ch, 1);
      checkOutput("mrst_ptr1_data", out_data, 8'h61);
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_out_valid", out_valid, 0);
      checkOutput("mrst_in_ready", in_ready, 4'b1111);
      checkOutput("mrst_out_ch", out_ch, 0);
      checkOutput("mrst_out_data", out_data, 0);
      tick();
      rst_n = 1'b1;
      applyStimulus(4'b1001, 32'h8300_0080, 1'b1);
      #1;
      checkOutput("mrst_release_valid", out_valid, 0);
      tick();
      applyStimulus(4'b0000, 32'h0, 1'b1);
      #1;
      checkOutput("mrst_grant0_ch", out_ch, 0);
      checkOutput("mrst_grant0_data", out_data, 8'h80);
      tick();
      checkOutput("mrst_grant1_ch", out_ch, 3);
      checkOutput("mrst_grant1_data", out_data, 8'h83);
      tick();
      checkOutput("mrst_empty_valid", out_valid, 0);

`ifdef INTF_ARRAY_RR_MUX_STATS_EN
      // Grant counters: ch0 streams past the saturation point.
      pulseReset();
      checkOutput("stats_reset", grant_cnt, 64'h0);
      applyStimulus(4'b0001, 32'h0000_00AA, 1'b1);
      repeat (70001) tick();
      applyStimulus(4'b0000, 32'h0, 1'b0);
      #1;
      checkOutput("stats_ch0_sat", grant_cnt[0], 16'hFFFF);
      checkOutput("stats_others", {grant_cnt[3], grant_cnt[2], grant_cnt[1]}, 48'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/intf_array_rr_mux.md
INTF_ARRAY_RR_MUX -- requirements
Module: intf_array_rr_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, giving the payload width in bits (legal range 1..64).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, [NUM_CH]: per-channel request valid.
REQ-006 SHALL have port in_data, input, [NUM_CH][WIDTH]: per-channel payload.
REQ-007 SHALL have port in_ready, output, [NUM_CH]: per-channel accept.
REQ-008 SHALL have port out_valid, output, 1 bit: merged output valid.
REQ-009 SHALL have port out_data, output, WIDTH: merged payload.
REQ-010 SHALL have port out_ch, output, $clog2(NUM_CH): source channel of out_data.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-012 SHALL hold one entry per channel (full[i], data[i]); an input transfer occurs when in_valid[i] & in_ready[i].
REQ-013 SHALL drive in_ready[i] = !full[i] | (out_valid & out_ready & out_ch==i): same-cycle drain and refill of one channel.
REQ-014 SHALL drive out_valid = |full; out_data = data[out_ch]; latency from input transfer to out_valid is exactly 1 cycle.
REQ-015 SHALL select out_ch round-robin: the first full channel at or after ptr, wrapping NUM_CH-1 -> 0.
REQ-016 SHALL, on an output transfer (out_valid & out_ready), clear full[out_ch] (unless refilled by REQ-013) and set ptr = out_ch+1, wrapping to 0.
REQ-017 SHALL lock the selection while out_valid & !out_ready: out_ch and out_data stay stable even if higher-priority channels fill.
REQ-018 SHALL behave as a two-state FSM, IDLE (no full entry) and PRESENT (out_valid=1); PRESENT->IDLE only on an output transfer that leaves no full entry.
REQ-019 SHALL ignore in_data when in_valid=0, and drive out_data and out_ch as 0 when out_valid=0.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-transfer, immediately clear all full[i] and data[i], set ptr=0, and drive out_valid=0, out_data=0, out_ch=0, in_ready=all-ones.
REQ-021 SHALL accept inputs on the first rising clk edge after rst_n deasserts.

Configuration
REQ-022 SHALL, with INTF_ARRAY_RR_MUX_STATS_EN defined, add output grant_cnt [NUM_CH][16]: per-channel count of output transfers, saturating at 16'hFFFF and reset to 0.
REQ-023 SHALL, without INTF_ARRAY_RR_MUX_STATS_EN, omit the grant_cnt port and its counters entirely; all other behaviour stays identical.

Structure
REQ-024 SHALL place the channel-index type (logic [$clog2(NUM_CH)-1:0]) and the STATS counter width (16) in the shared package intf_array_rr_pkg.
REQ-025 SHALL instantiate the sub-module intf_array_rr_slot once per channel, in a generate for loop over an array of chan_intf interface instances, each carrying valid, ready and data.
REQ-026 SHALL keep the arbiter, ptr and lock logic in the top module.

Verification
REQ-027 SHALL cover the single-channel case: NUM_CH=4, WIDTH=8, ch2 sends 8'hA5 with out_ready=1 -> next cycle out_valid=1, out_ch=2, out_data=8'hA5; the cycle after, out_valid=0.
REQ-028 SHALL cover fairness: all 4 channels continuously valid with out_ready=1 -> out_ch sequence 0,1,2,3,0,1... with no repeats.
REQ-029 SHALL cover stall lock: ch1 presented with out_ready=0, then ch0 fills -> out_ch stays 1 and out_data stays unchanged until out_ready=1; the next grant is ch2 or later, then ch0.
REQ-030 SHALL cover drain plus refill: ch3 full and granted with out_ready=1 while in_valid[3]=1 (8'h3C) -> in_ready[3]=1, and 8'h3C is presented in a later cycle with no lost or duplicated beat.
REQ-031 SHALL cover mid-operation reset: rst_n pulsed low with 3 channels full -> out_valid=0 and in_ready=4'b1111 before the next clk edge; after release the first grant follows ptr=0.
REQ-032 SHALL cover STATS: with INTF_ARRAY_RR_MUX_STATS_EN, 70000 grants on ch0 -> grant_cnt[0]=16'hFFFF and the other counters unchanged.
